// File: rtl/i2c_init_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_init_sequencer
//
// Power-up configuration sequencer. Walks a register table held in a
// synchronous ROM (1-cycle read latency) and issues one single-byte I2C write
// per entry through the single-master I2C block. Table entries are
// {sub_addr[15:8], data[7:0]}:
//   16'hFFFF          end marker
//   {8'hFE, n}        delay of n milliseconds (n = 0 is a zero-length delay)
//   anything else     write data to register sub_addr
//
// Ports:
//   clk_50           system clock (50 MHz)
//   reset            asynchronous reset, active-high
//   start            begins the sequence; honoured only in IDLE, DONE or ERROR
//   tbl_addr         table index presented to the ROM
//   tbl_data         ROM entry, valid one cycle after tbl_addr
//   i2c_request      transaction request to the I2C master
//   i2c_wr           constant 1 (write)
//   i2c_length       constant 1 byte
//   i2c_address      7-bit device address (DEV_ADDR)
//   i2c_sub_address  register address of the current entry
//   i2c_tx           data byte of the current entry
//   i2c_busy         busy flag from the I2C master (asynchronous)
//   seq_busy         high while the sequence runs
//   done             level, set when the end marker (or last index) is reached
//   error            level, set when a transaction phase times out
//   err_idx          table index of the entry that timed out
// -----------------------------------------------------------------------------
module i2c_init_sequencer #(
  parameter logic [6:0] DEV_ADDR       = 7'h20,
  parameter int         ADDR_W         = 8,
  parameter int         MS_CYCLES      = 50000,
  parameter int         TIMEOUT_CYCLES = 2000000,
  parameter int         GAP_CYCLES     = 256
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              i2c_request,
  output logic              i2c_wr,
  output logic [7:0]        i2c_length,
  output logic [6:0]        i2c_address,
  output logic [7:0]        i2c_sub_address,
  output logic [7:0]        i2c_tx,
  input  logic              i2c_busy,
  output logic              seq_busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_idx
);

  // One counter serves delay, gap and timeout; it is sized for the largest.
  localparam int DELAY_MAX = 255 * MS_CYCLES;
  localparam int MAX_DT    = (DELAY_MAX > TIMEOUT_CYCLES) ? DELAY_MAX : TIMEOUT_CYCLES;
  localparam int CNT_MAX   = (MAX_DT > GAP_CYCLES) ? MAX_DT : GAP_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] MS_C      = CNT_W'(MS_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_C     = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, REQ, WAIT_HI, WAIT_LO, GAP, DELAY, DONE, ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt, err_idx_nxt;
  logic [7:0]        sub_nxt, tx_nxt;
  logic              seq_busy_nxt, done_nxt, error_nxt;
  logic              advance, expire;
  logic              busy_meta, busy_s;

  assign i2c_wr      = 1'b1;
  assign i2c_length  = 8'd1;
  assign i2c_address = DEV_ADDR;

  // Two-flop synchronizer: i2c_busy comes from another timing domain.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= i2c_busy;
      busy_s    <= busy_meta;
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      tbl_addr        <= '0;
      i2c_sub_address <= 8'h00;
      i2c_tx          <= 8'h00;
      cnt             <= '0;
      seq_busy        <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      err_idx         <= '0;
    end else begin
      state           <= state_nxt;
      tbl_addr        <= addr_nxt;
      i2c_sub_address <= sub_nxt;
      i2c_tx          <= tx_nxt;
      cnt             <= cnt_nxt;
      seq_busy        <= seq_busy_nxt;
      done            <= done_nxt;
      error           <= error_nxt;
      err_idx         <= err_idx_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    state_nxt    = state;
    addr_nxt     = tbl_addr;
    sub_nxt      = i2c_sub_address;
    tx_nxt       = i2c_tx;
    cnt_nxt      = cnt;
    seq_busy_nxt = seq_busy;
    done_nxt     = done;
    error_nxt    = error;
    err_idx_nxt  = err_idx;
    i2c_request  = 1'b0;
    advance      = 1'b0;
    expire       = 1'b0;

    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_nxt    = FETCH;
          addr_nxt     = '0;
          done_nxt     = 1'b0;
          error_nxt    = 1'b0;
          err_idx_nxt  = '0;
          seq_busy_nxt = 1'b1;
        end
      end

      // ROM read latency.
      FETCH: state_nxt = DECODE;

      DECODE: begin
        if (tbl_data == 16'hFFFF) begin
          state_nxt    = DONE;
          done_nxt     = 1'b1;
          seq_busy_nxt = 1'b0;
        end else if (tbl_data[15:8] == 8'hFE) begin
          // A zero-length delay skips DELAY so it costs no extra cycle.
          if (tbl_data[7:0] == 8'h00) begin
            advance = 1'b1;
          end else begin
            cnt_nxt   = CNT_W'(tbl_data[7:0]) * MS_C;
            state_nxt = DELAY;
          end
        end else begin
          sub_nxt   = tbl_data[15:8];
          tx_nxt    = tbl_data[7:0];
          cnt_nxt   = TIMEOUT_C;
          state_nxt = REQ;
        end
      end

      // After a mid-transfer reset the master may still be busy; hold off the
      // request until it is idle. This wait counts against the timeout.
      REQ: begin
        if (!busy_s) begin
          i2c_request = 1'b1;
          cnt_nxt     = TIMEOUT_C;
          state_nxt   = WAIT_HI;
        end else if (cnt <= CNT_ONE) begin
          expire = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      // Request drops in the very cycle busy is seen, so it is low before the
      // master finishes and cannot retrigger a second transfer.
      WAIT_HI: begin
        if (busy_s) begin
          cnt_nxt   = TIMEOUT_C;
          state_nxt = WAIT_LO;
        end else if (cnt <= CNT_ONE) begin
          expire = 1'b1;
        end else begin
          i2c_request = 1'b1;
          cnt_nxt     = cnt - CNT_ONE;
        end
      end

      WAIT_LO: begin
        if (!busy_s) begin
          cnt_nxt   = GAP_C;
          state_nxt = GAP;
        end else if (cnt <= CNT_ONE) begin
          expire = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      GAP, DELAY: begin
        if (cnt <= CNT_ONE) begin
          advance = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (expire) begin
      state_nxt    = ERROR;
      error_nxt    = 1'b1;
      err_idx_nxt  = tbl_addr;
      seq_busy_nxt = 1'b0;
      cnt_nxt      = '0;
    end

    // The index never wraps: running off the last entry ends the sequence.
    if (advance) begin
      if (tbl_addr == '1) begin
        state_nxt    = DONE;
        done_nxt     = 1'b1;
        seq_busy_nxt = 1'b0;
      end else begin
        addr_nxt  = tbl_addr + ADDR_W'(1);
        state_nxt = FETCH;
      end
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2c_init_sequencer
//
// Self-checking bench for i2c_init_sequencer. A synchronous ROM model feeds
// the table, a simple I2C master model raises busy after each request and
// records the (sub_address, data) pairs it was asked to write, and a table
// model derives the expected write list and final index from the entry rules.
// -----------------------------------------------------------------------------
module tb_i2c_init_sequencer;

  localparam logic [6:0] DEV_ADDR       = 7'h2A;
  localparam int         ADDR_W         = 8;
  localparam int         DEPTH          = 2 ** ADDR_W;
  localparam int         MS_CYCLES      = 10;
  localparam int         TIMEOUT_CYCLES = 1200;
  localparam int         GAP_CYCLES     = 16;
  localparam int         MASTER_LAT     = 2;

  logic              clk_50 = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] tbl_addr;
  logic [15:0]       tbl_data;
  logic              i2c_request;
  logic              i2c_wr;
  logic [7:0]        i2c_length;
  logic [6:0]        i2c_address;
  logic [7:0]        i2c_sub_address;
  logic [7:0]        i2c_tx;
  logic              i2c_busy;
  logic              seq_busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] err_idx;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] rom [DEPTH];
  bit          master_en    = 1'b1;
  int          busy_len     = 100;
  int          drop_lat_max = 0;
  logic [15:0] txn_q[$];
  int          txn_cyc_q[$];
  int          done_rises = 0;
  logic [15:0] exp_q[$];
  int          exp_end;

  i2c_init_sequencer #(
    .DEV_ADDR      (DEV_ADDR),
    .ADDR_W        (ADDR_W),
    .MS_CYCLES     (MS_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES)
  ) u_dut (
    .clk_50         (clk_50),
    .reset          (reset),
    .start          (start),
    .tbl_addr       (tbl_addr),
    .tbl_data       (tbl_data),
    .i2c_request    (i2c_request),
    .i2c_wr         (i2c_wr),
    .i2c_length     (i2c_length),
    .i2c_address    (i2c_address),
    .i2c_sub_address(i2c_sub_address),
    .i2c_tx         (i2c_tx),
    .i2c_busy       (i2c_busy),
    .seq_busy       (seq_busy),
    .done           (done),
    .error          (error),
    .err_idx        (err_idx)
  );

  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  // Synchronous ROM, one cycle of read latency.
  always @(posedge clk_50) tbl_data <= rom[tbl_addr];

  // I2C master model: accepts a request seen while idle, raises busy after a
  // short latency for busy_len cycles, and measures how long request stays up.
  initial begin : master_model
    int lat;
    i2c_busy = 1'b0;
    forever begin
      @(negedge clk_50);
      if (master_en && i2c_request === 1'b1 && !i2c_busy) begin
        txn_q.push_back({i2c_sub_address, i2c_tx});
        txn_cyc_q.push_back(cyc);
        repeat (MASTER_LAT) @(negedge clk_50);
        i2c_busy = 1'b1;
        lat = -1;
        for (int k = 1; k <= busy_len; k++) begin
          @(negedge clk_50);
          if (lat < 0 && i2c_request !== 1'b1) lat = k;
        end
        if (lat < 0) lat = busy_len;
        if (lat > drop_lat_max) drop_lat_max = lat;
        i2c_busy = 1'b0;
      end
    end
  end

  initial begin : done_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk_50);
      #1;
      if (done === 1'b1 && prev !== 1'b1) done_rises++;
      prev = done;
    end
  end

  initial begin : watchdog
    #(20 * 100000);
    $display("FAIL watchdog: simulation did not finish within 100000 cycles");
    $fatal(1);
  end

  // Reference model: writes in table order up to the end marker; the final
  // index is the end marker's position, or the last index if there is none.
  function automatic void model_table();
    exp_q.delete();
    exp_end = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (rom[i] == 16'hFFFF) begin
        exp_end = i;
        break;
      end
      if (rom[i][15:8] != 8'hFE) exp_q.push_back(rom[i]);
    end
  endfunction

  task automatic clear_rom(input logic [15:0] fill);
    for (int i = 0; i < DEPTH; i++) rom[i] = fill;
    txn_q.delete();
    txn_cyc_q.delete();
    drop_lat_max = 0;
  endtask

  task automatic pulse_start(output int c0);
    @(negedge clk_50);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk_50);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int end_cyc);
    end_cyc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_50);
      if (done === 1'b1 || error === 1'b1) begin
        end_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    clear_rom(16'hFFFF);
    repeat (3) @(negedge clk_50);
    n_checks++;
    if ({i2c_request, seq_busy, done, error} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: req/busy/done/err got %b expected 0000", {i2c_request, seq_busy, done, error});
    end
    n_checks++;
    if ({tbl_addr, err_idx, i2c_sub_address, i2c_tx} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: addr=%h err_idx=%h sub=%h tx=%h expected all 0", tbl_addr, err_idx, i2c_sub_address, i2c_tx);
    end
    n_checks++;
    if (i2c_wr !== 1'b1 || i2c_length !== 8'd1 || i2c_address !== DEV_ADDR) begin
      n_fail++;
      $display("FAIL reset_consts: wr=%b len=%0d addr=%h expected 1/1/%h", i2c_wr, i2c_length, i2c_address, DEV_ADDR);
    end
    reset = 1'b0;
  endtask

  task automatic check_sequence(input string name, input int end_cyc);
    n_checks++;
    if (end_cyc < 0) begin
      n_fail++;
      $display("FAIL %s_end: sequence did not finish within budget", name);
    end
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0 || seq_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_status: done=%b error=%b seq_busy=%b expected 1/0/0", name, done, error, seq_busy);
    end
    n_checks++;
    if (int'(tbl_addr) !== exp_end) begin
      n_fail++;
      $display("FAIL %s_tbl_addr: got %0d expected %0d", name, tbl_addr, exp_end);
    end
    n_checks++;
    if (txn_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_txn_count: got %0d expected %0d", name, txn_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < txn_q.size(); i++) begin
      n_checks++;
      if (txn_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_txn%0d: got sub/data %h expected %h", name, i, txn_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_two_writes();
    int c0, e;
    clear_rom(16'hFFFF);
    rom[0] = 16'h0F00;
    rom[1] = 16'h105A;
    model_table();
    master_en = 1'b1;
    busy_len  = 1000;
    pulse_start(c0);
    wait_end(5000, e);
    check_sequence("two_writes", e);
    n_checks++;
    if (txn_cyc_q.size() < 1 || txn_cyc_q[0] !== c0 + 3) begin
      n_fail++;
      $display("FAIL two_writes_first_req: got cycle %0d expected %0d", (txn_cyc_q.size() > 0) ? txn_cyc_q[0] - c0 : -1, 3);
    end
    n_checks++;
    if (drop_lat_max > 3 || drop_lat_max < 1) begin
      n_fail++;
      $display("FAIL two_writes_req_drop: request stayed high %0d cycles after busy, expected 1..3", drop_lat_max);
    end
  endtask

  task automatic test_delay();
    int c0, e, exp_req;
    clear_rom(16'hFFFF);
    rom[0] = 16'hFE02;
    rom[1] = 16'h01AA;
    model_table();
    busy_len = 50;
    pulse_start(c0);
    wait_end(3000, e);
    check_sequence("delay", e);
    // Delay decoded at c0+2; the next entry is fetched data*MS_CYCLES+1 later.
    exp_req = c0 + 2 + 2 * MS_CYCLES + 1 + 2;
    n_checks++;
    if (txn_cyc_q.size() < 1 || txn_cyc_q[0] < exp_req - 1 || txn_cyc_q[0] > exp_req + 1) begin
      n_fail++;
      $display("FAIL delay_first_req: got %0d cycles after start expected %0d", (txn_cyc_q.size() > 0) ? txn_cyc_q[0] - c0 : -1, exp_req - c0);
    end
  endtask

  task automatic test_end_first();
    int c0;
    clear_rom(16'hFFFF);
    pulse_start(c0);
    @(negedge clk_50);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL end_first_early: done=%b at start+2 expected 0", done);
    end
    repeat (2) @(negedge clk_50);
    n_checks++;
    if (done !== 1'b1 || tbl_addr !== '0) begin
      n_fail++;
      $display("FAIL end_first_done: done=%b tbl_addr=%0d at start+4 expected 1/0", done, tbl_addr);
    end
    n_checks++;
    if (txn_q.size() !== 0) begin
      n_fail++;
      $display("FAIL end_first_no_req: got %0d requests expected 0", txn_q.size());
    end
  endtask

  task automatic test_random_tables();
    int c0, e, n, r;
    for (int t = 0; t < 4; t++) begin
      clear_rom(16'hFFFF);
      n = $urandom_range(2, 5);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        if (r < 2)       rom[i] = {8'hFE, 8'($urandom_range(0, 3))};
        else if (r == 2) rom[i] = {8'hFF, 8'($urandom_range(0, 254))};
        else             rom[i] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
      end
      model_table();
      busy_len = $urandom_range(20, 200);
      pulse_start(c0);
      wait_end(20000, e);
      check_sequence($sformatf("random%0d", t), e);
    end
  endtask

  task automatic test_start_ignored();
    int c0, c1, e, n;
    clear_rom(16'hFFFF);
    rom[0] = 16'h3001;
    rom[1] = 16'h3102;
    model_table();
    busy_len   = 200;
    pulse_start(c0);
    done_rises = 0;
    n = 0;
    while (i2c_busy !== 1'b1 && n < 100) begin
      @(negedge clk_50);
      n++;
    end
    repeat (10) @(negedge clk_50);
    pulse_start(c1);
    n_checks++;
    if (seq_busy !== 1'b1 || tbl_addr !== '0) begin
      n_fail++;
      $display("FAIL start_ignored_state: seq_busy=%b tbl_addr=%0d expected 1/0", seq_busy, tbl_addr);
    end
    wait_end(3000, e);
    check_sequence("start_ignored", e);
    repeat (3) @(negedge clk_50);
    n_checks++;
    if (done_rises !== 1) begin
      n_fail++;
      $display("FAIL start_ignored_done_once: done rose %0d times expected 1", done_rises);
    end
  endtask

  task automatic test_index_limit();
    int c0, e;
    clear_rom(16'hFE00);
    model_table();
    pulse_start(c0);
    wait_end(2000, e);
    check_sequence("index_limit", e);
  endtask

  task automatic test_timeout();
    int c0, e, exp_e;
    master_en = 1'b0;
    clear_rom(16'hFFFF);
    rom[0] = 16'h4055;
    pulse_start(c0);
    wait_end(TIMEOUT_CYCLES + 100, e);
    exp_e = c0 + 4 + TIMEOUT_CYCLES;
    n_checks++;
    if (e < exp_e - 1 || e > exp_e + 1) begin
      n_fail++;
      $display("FAIL timeout_cycle: error after %0d cycles expected %0d", (e < 0) ? -1 : e - c0, exp_e - c0);
    end
    n_checks++;
    if (error !== 1'b1 || done !== 1'b0 || err_idx !== '0 || i2c_request !== 1'b0 || seq_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_status: err=%b done=%b idx=%0d req=%b busy=%b expected 1/0/0/0/0", error, done, err_idx, i2c_request, seq_busy);
    end
    // Restart with the write at index 1 so err_idx must follow the index.
    clear_rom(16'hFFFF);
    rom[0] = 16'hFE00;
    rom[1] = 16'h4155;
    pulse_start(c0);
    n_checks++;
    if (error !== 1'b0 || seq_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_restart_clear: error=%b seq_busy=%b expected 0/1", error, seq_busy);
    end
    wait_end(TIMEOUT_CYCLES + 100, e);
    n_checks++;
    if (error !== 1'b1 || int'(err_idx) !== 1) begin
      n_fail++;
      $display("FAIL timeout_err_idx: error=%b err_idx=%0d expected 1/1", error, err_idx);
    end
    master_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int c0, e, n, streak;
    bit seen;
    clear_rom(16'hFFFF);
    rom[0] = 16'h2011;
    rom[1] = 16'h2122;
    model_table();
    busy_len = 600;
    pulse_start(c0);
    n = 0;
    while (i2c_busy !== 1'b1 && n < 100) begin
      @(negedge clk_50);
      n++;
    end
    repeat (20) @(negedge clk_50);
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({i2c_request, seq_busy, done, error} !== 4'b0000 ||
        {tbl_addr, err_idx, i2c_sub_address, i2c_tx} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: req=%b busy=%b done=%b err=%b addr=%h sub=%h tx=%h expected all 0",
               i2c_request, seq_busy, done, error, tbl_addr, i2c_sub_address, i2c_tx);
    end
    @(negedge clk_50);
    @(negedge clk_50);
    reset = 1'b0;
    txn_q.delete();
    txn_cyc_q.delete();
    pulse_start(c0);
    streak = 0;
    seen   = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(posedge clk_50);
      #1;
      if (i2c_busy === 1'b0) streak++;
      else streak = 0;
      if (i2c_request === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || streak < 2) begin
      n_fail++;
      $display("FAIL reset_mid_req_hold: request seen=%b after busy low %0d cycles expected >=2", seen, streak);
    end
    wait_end(5000, e);
    check_sequence("reset_mid", e);
  endtask

  initial begin : main
    test_reset();
    test_two_writes();
    test_delay();
    test_end_first();
    test_random_tables();
    test_start_ignored();
    test_index_limit();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
